heap_pq_param: RTL
==================

// Module: heap_pq_param
// PURPOSE
//  Parametrised binary-heap priority queue with selectable min/max ordering.
//  Storage is internal: array A[1..CAP], where CAP = 2**ADDR_W-1.
//  Loads an initial data stream, then executes commands: build, extract,
//  insert, key-raise, peek and dump-to-RAM.
//  Unlike its predecessor, it has bounds/error checking, extract/peek data
//  output, occupancy flags, and returns to command wait after a dump.
// PARAMETERS
//  DATA_W  8  key width, unsigned
//  ADDR_W  8  index width; capacity CAP = 2**ADDR_W-1
//  MODE    0  0 = min-heap (root is smallest key); 1 = max-heap (root is largest key)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  data_valid  in   1       load-phase data strobe
//  data        in   DATA_W  load-phase key
//  cmd_valid   in   1       command strobe; sampled only when busy=0
//  cmd         in   3       0 BUILD, 1 EXTRACT, 2 RAISE, 3 INSERT, 4 WRITE, 5 PEEK, 6/7 illegal
//  index       in   ADDR_W  RAISE target index (1-based)
//  value       in   DATA_W  RAISE/INSERT key
//  busy        out  1       1 = command in progress
//  out_valid   out  1       1-cycle pulse; out_data is valid (EXTRACT/PEEK)
//  out_data    out  DATA_W  root key
//  err         out  1       1-cycle pulse: rejected command or dropped load word
//  count       out  ADDR_W  current element count num
//  full        out  1       num == CAP
//  empty       out  1       num == 0
//  RAM_valid   out  1       RAM write strobe
//  RAM_A       out  ADDR_W  RAM address, 0-based
//  RAM_D       out  DATA_W  RAM data
//  done        out  1       1-cycle pulse: WRITE finished
// BEHAVIOUR
//  Reset:
//   - All outputs 0; num=0; FSM enters LOAD. Array contents are don't-care.
//   - rst mid-operation aborts immediately; no partial RAM writes after that edge.
//  Priority:
//   - "higher(a,b)" means a<b when MODE=0, a>b when MODE=1.
//   - Ties never swap.
//  FSM states: LOAD, WAIT, BUILD, HEAPIFY, EXTRACT, INSERT, SIFTUP, WRITE.
//   - LOAD: each cycle with data_valid=1 sets A[num+1]=data and num=num+1.
//     - If full, the word is dropped and err pulses.
//     - The first data_valid=0 cycle after at least one accepted word moves to WAIT.
//     - busy=1 throughout LOAD.
//   - WAIT: busy=0. cmd_valid=1 latches cmd/index/value; busy=1 from the next cycle.
//   - busy returns to 0 in the cycle the FSM re-enters WAIT.
//  BUILD:
//   - Sets i=num>>1, then runs HEAPIFY(i) for i down to 1, then goes to WAIT.
//   - num<=1 is a no-op; returns to WAIT in 2 cycles.
//  HEAPIFY:
//   - One compare-and-swap per cycle between node i and its higher-priority child.
//   - A child c is considered only if c <= num.
//   - Ends when no child is higher.
//  EXTRACT:
//   - empty: err pulse; no change.
//   - Otherwise: out_valid pulses with out_data=A[1], then A[1]=A[num], num-=1, HEAPIFY(1).
//  PEEK:
//   - empty: err pulse.
//   - Otherwise: out_valid pulses with out_data=A[1]; heap unchanged; WAIT next cycle.
//  INSERT:
//   - full: err pulse.
//   - Otherwise: A[num+1]=value, num+=1, then SIFTUP from num.
//  RAISE:
//   - err (no change) if index==0, index>num, or !higher(value,A[index]).
//   - Otherwise: A[index]=value, then SIFTUP.
//  SIFTUP:
//   - While i>1 && higher(A[i],A[i>>1]): swap, i=i>>1. One level per cycle.
//  WRITE:
//   - For k=0..num-1, one word per cycle: RAM_valid=1, RAM_A=k, RAM_D=A[k+1].
//   - done pulses with the last word, then the FSM returns to WAIT; heap contents are kept.
//   - num==0: done pulses with no RAM_valid.
//  Illegal cmd: err pulse; WAIT next cycle.
//  Arithmetic:
//   - Child index 2i/2i+1 is computed at ADDR_W+1 bits, so overflow never aliases.
//   - count/full/empty are registered and updated with num.
// TESTING
//  - MODE=1, load 4,1,3,2,16,9,10,14,8,7 then BUILD, WRITE -> RAM_D sequence
//    16,14,10,8,7,9,3,2,4,1; RAM_A 0..9; done with word 9.
//  - MODE=1 after BUILD: EXTRACT x3 -> out_data 16,14,10; count 7.
//  - MODE=0, load 5,3,8 then BUILD, INSERT 1 -> PEEK gives 1; RAISE index=2 value=9 -> err, no change.
//  - ADDR_W=2 (CAP=3): load 4 words -> 4th dropped, err pulse; INSERT -> err; EXTRACT x4 -> 4th gives err, empty=1.
//  - rst asserted mid-WRITE at k=3 -> next cycle all outputs 0, RAM_valid stays 0, FSM in LOAD.
//  - cmd=6 in WAIT -> err 1 cycle, busy 1 for one cycle, heap unchanged.

Source files
------------

// File: rtl/heap_pq_param.sv
// Binary-heap priority queue (min or max by MODE) with load phase, command set,
// bounds/error checking, registered occupancy flags and a dump-to-RAM port.
module heap_pq_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter bit MODE   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              err,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              RAM_valid,
    output logic [ADDR_W-1:0] RAM_A,
    output logic [DATA_W-1:0] RAM_D,
    output logic              done
);

    localparam logic [ADDR_W-1:0] CAP_IDX = '1;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    localparam logic [2:0] CMD_BUILD   = 3'd0;
    localparam logic [2:0] CMD_EXTRACT = 3'd1;
    localparam logic [2:0] CMD_RAISE   = 3'd2;
    localparam logic [2:0] CMD_INSERT  = 3'd3;
    localparam logic [2:0] CMD_WRITE   = 3'd4;
    localparam logic [2:0] CMD_PEEK    = 3'd5;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT,
        S_BUILD,
        S_HEAPIFY,
        S_EXTRACT,
        S_INSERT,
        S_SIFTUP,
        S_WRITE
    } state_t;

    function automatic logic higher(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return MODE ? (a > b) : (a < b);
    endfunction

    // Slot 0 is never used; sizing the array to 2**ADDR_W keeps every index in range.
    logic [DATA_W-1:0] heap [0:CAP_IDX];

    state_t            state, state_n;
    logic [ADDR_W-1:0] num, num_n;
    logic [ADDR_W-1:0] node, node_n;
    logic [ADDR_W-1:0] build_i, build_n;
    logic [ADDR_W-1:0] k, k_n;
    logic [2:0]        cmd_q, cmd_n;
    logic [ADDR_W-1:0] index_q, index_n;
    logic [DATA_W-1:0] value_q, value_n;

    logic              out_valid_n, err_n, ram_valid_n, done_n;
    logic [DATA_W-1:0] out_data_n, ram_d_n;
    logic [ADDR_W-1:0] ram_a_n;

    logic              we_a, we_b;
    logic [ADDR_W-1:0] wa_addr, wb_addr;
    logic [DATA_W-1:0] wa_data, wb_data;

    logic [ADDR_W:0]   l_w, r_w;
    logic              l_ok, r_ok;
    logic [ADDR_W-1:0] l_idx, r_idx, parent, best_idx;
    logic [DATA_W-1:0] node_val, l_val, r_val, parent_val, best_val;
    logic [DATA_W-1:0] root_val, last_val, idx_val, k_val;

    // Child indices carry one extra bit so 2i+1 beyond CAP never wraps onto a real node.
    assign l_w        = {node, 1'b0};
    assign r_w        = {node, 1'b1};
    assign l_ok       = (l_w <= {1'b0, num});
    assign r_ok       = (r_w <= {1'b0, num});
    assign l_idx      = l_w[ADDR_W-1:0];
    assign r_idx      = r_w[ADDR_W-1:0];
    assign parent     = node >> 1;
    assign node_val   = heap[node];
    assign l_val      = heap[l_idx];
    assign r_val      = heap[r_idx];
    assign parent_val = heap[parent];
    assign root_val   = heap[ONE];
    assign last_val   = heap[num];
    assign idx_val    = heap[index_q];
    assign k_val      = heap[k + ONE];
    assign count      = num;

    // Strict comparisons: on equal keys the parent (or left child) wins.
    always_comb begin
        best_idx = node;
        best_val = node_val;
        if (l_ok && higher(l_val, best_val)) begin
            best_idx = l_idx;
            best_val = l_val;
        end
        if (r_ok && higher(r_val, best_val)) begin
            best_idx = r_idx;
            best_val = r_val;
        end
    end

    always_comb begin
        state_n     = state;
        num_n       = num;
        node_n      = node;
        build_n     = build_i;
        k_n         = k;
        cmd_n       = cmd_q;
        index_n     = index_q;
        value_n     = value_q;
        out_valid_n = 1'b0;
        out_data_n  = out_data;
        err_n       = 1'b0;
        ram_valid_n = 1'b0;
        ram_a_n     = RAM_A;
        ram_d_n     = RAM_D;
        done_n      = 1'b0;
        we_a        = 1'b0;
        wa_addr     = '0;
        wa_data     = '0;
        we_b        = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;

        case (state)
            S_LOAD: begin
                if (data_valid) begin
                    if (num == CAP_IDX) begin
                        err_n = 1'b1;
                    end else begin
                        we_a    = 1'b1;
                        wa_addr = num + ONE;
                        wa_data = data;
                        num_n   = num + ONE;
                    end
                end else if (num != '0) begin
                    state_n = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cmd_valid) begin
                    cmd_n   = cmd;
                    index_n = index;
                    value_n = value;
                    k_n     = '0;
                    case (cmd)
                        CMD_BUILD:             state_n = S_BUILD;
                        CMD_RAISE, CMD_INSERT: state_n = S_INSERT;
                        CMD_WRITE:             state_n = S_WRITE;
                        // EXTRACT, PEEK and illegal codes all resolve in one result cycle.
                        default:               state_n = S_EXTRACT;
                    endcase
                end
            end

            S_BUILD: begin
                if ((num >> 1) == '0) begin
                    state_n = S_WAIT;
                end else begin
                    build_n = num >> 1;
                    node_n  = num >> 1;
                    state_n = S_HEAPIFY;
                end
            end

            S_HEAPIFY: begin
                if (best_idx != node) begin
                    we_a    = 1'b1;
                    wa_addr = node;
                    wa_data = best_val;
                    we_b    = 1'b1;
                    wb_addr = best_idx;
                    wb_data = node_val;
                    node_n  = best_idx;
                end else if (build_i > ONE) begin
                    build_n = build_i - ONE;
                    node_n  = build_i - ONE;
                end else begin
                    state_n = S_WAIT;
                end
            end

            S_EXTRACT: begin
                state_n = S_WAIT;
                if (cmd_q == CMD_EXTRACT) begin
                    if (num == '0) begin
                        err_n = 1'b1;
                    end else begin
                        out_valid_n = 1'b1;
                        out_data_n  = root_val;
                        we_a        = 1'b1;
                        wa_addr     = ONE;
                        wa_data     = last_val;
                        num_n       = num - ONE;
                        node_n      = ONE;
                        build_n     = '0;
                        state_n     = S_HEAPIFY;
                    end
                end else if (cmd_q == CMD_PEEK) begin
                    if (num == '0) begin
                        err_n = 1'b1;
                    end else begin
                        out_valid_n = 1'b1;
                        out_data_n  = root_val;
                    end
                end else begin
                    err_n = 1'b1;
                end
            end

            S_INSERT: begin
                state_n = S_WAIT;
                if (cmd_q == CMD_INSERT) begin
                    if (num == CAP_IDX) begin
                        err_n = 1'b1;
                    end else begin
                        we_a    = 1'b1;
                        wa_addr = num + ONE;
                        wa_data = value_q;
                        num_n   = num + ONE;
                        node_n  = num + ONE;
                        state_n = S_SIFTUP;
                    end
                end else if (index_q == '0 || index_q > num || !higher(value_q, idx_val)) begin
                    err_n = 1'b1;
                end else begin
                    we_a    = 1'b1;
                    wa_addr = index_q;
                    wa_data = value_q;
                    node_n  = index_q;
                    state_n = S_SIFTUP;
                end
            end

            S_SIFTUP: begin
                if (node > ONE && higher(node_val, parent_val)) begin
                    we_a    = 1'b1;
                    wa_addr = node;
                    wa_data = parent_val;
                    we_b    = 1'b1;
                    wb_addr = parent;
                    wb_data = node_val;
                    node_n  = parent;
                end else begin
                    state_n = S_WAIT;
                end
            end

            S_WRITE: begin
                if (num == '0) begin
                    done_n  = 1'b1;
                    state_n = S_WAIT;
                end else begin
                    ram_valid_n = 1'b1;
                    ram_a_n     = k;
                    ram_d_n     = k_val;
                    if (k == num - ONE) begin
                        done_n  = 1'b1;
                        state_n = S_WAIT;
                    end else begin
                        k_n = k + ONE;
                    end
                end
            end

            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            num       <= '0;
            node      <= '0;
            build_i   <= '0;
            k         <= '0;
            cmd_q     <= '0;
            index_q   <= '0;
            value_q   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b0;
            RAM_valid <= 1'b0;
            RAM_A     <= '0;
            RAM_D     <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            num       <= num_n;
            node      <= node_n;
            build_i   <= build_n;
            k         <= k_n;
            cmd_q     <= cmd_n;
            index_q   <= index_n;
            value_q   <= value_n;
            busy      <= (state_n != S_WAIT);
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            err       <= err_n;
            full      <= (num_n == CAP_IDX);
            empty     <= (num_n == '0);
            RAM_valid <= ram_valid_n;
            RAM_A     <= ram_a_n;
            RAM_D     <= ram_d_n;
            done      <= done_n;
        end
    end

    // Heap contents need no reset; writes are simply suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we_a) heap[wa_addr] <= wa_data;
            if (we_b) heap[wb_addr] <= wb_data;
        end
    end

endmodule
